mem_load_unit: RTL

Parametrised, handshaked successor to the combinational load-data receiver. It accepts a load request (address, func3, tag) and issues one or two aligned memory beats. It merges and aligns the returned data, then sign- or zero-extends it. It sits between the LSU address stage and the data memory port, and supports XLEN=32/64 with optional split of misaligned, word-crossing loads.

---
 rtl/mem_pkg.sv | 37 +++
 rtl/load_align_extend.sv | 44 ++++
 rtl/mem_load_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the load unit: func3 encodings, response error codes,
// controller state encoding and the func3 legality helper.
package mem_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
        RESP  = 3'd5
    } state_t;

    // Doubleword and unsigned-word loads exist only on a 64-bit datapath.
    function automatic logic func3_legal(input logic [2:0] func3, input logic is_rv64);
        logic legal;
        case (func3)
            LB, LH, LW, LBU, LHU: legal = 1'b1;
            LD, LWU:              legal = is_rv64;
            default:              legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/load_align_extend.sv
// Combinational byte/half/word/double select from a two-beat window,
// followed by sign or zero extension to XLEN.
module load_align_extend #(
    parameter int XLEN  = 32,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  lo,
    input  logic [XLEN-1:0]  hi,
    input  logic [OFF_W-1:0] off,
    input  logic [2:0]       func3,
    output logic [XLEN-1:0]  result
);

    logic [XLEN-1:0] shifted_s;
    logic [XLEN-1:0] keep_s;
    logic            sign_s;
    logic            ext_s;

    // Shift the addressed byte to bit 0, keep the access size, fill the rest.
    always_comb begin
        shifted_s = XLEN'({hi, lo} >> {off, 3'b000});
        case (func3[1:0])
            2'b00: begin
                keep_s = XLEN'(8'hFF);
                sign_s = shifted_s[7];
            end
            2'b01: begin
                keep_s = XLEN'(16'hFFFF);
                sign_s = shifted_s[15];
            end
            2'b10: begin
                keep_s = XLEN'(32'hFFFF_FFFF);
                sign_s = shifted_s[31];
            end
            default: begin
                keep_s = {XLEN{1'b1}};
                sign_s = shifted_s[XLEN-1];
            end
        endcase
        ext_s  = ~func3[2] & sign_s;
        result = (shifted_s & keep_s) | ({XLEN{ext_s}} & ~keep_s);
    end

endmodule

// File: rtl/mem_load_unit.sv
// Handshaked load unit: one or two aligned memory beats per load, then align/extend.
// Define MEM_LOAD_SPLIT_EN to split word-crossing loads into two beats.
module mem_load_unit
    import mem_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_func3,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [1:0]        rsp_err
);

    localparam int NBYTES = XLEN / 8;
    localparam int OFF_W  = $clog2(NBYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK  = ~ADDR_W'(NBYTES - 1);
    localparam logic [ADDR_W-1:0] BEAT_STRIDE = ADDR_W'(NBYTES);

    state_t            state_r;
    state_t            state_nxt_s;
    logic              req_ready_r;
    logic              mem_req_valid_r;
    logic              rsp_valid_r;
    logic [ADDR_W-1:0] mem_req_addr_r;
    logic [XLEN-1:0]   rsp_data_r;
    logic [TAG_W-1:0]  rsp_tag_r;
    logic [1:0]        rsp_err_r;
    logic [OFF_W-1:0]  off_r;
    logic [2:0]        func3_r;
`ifdef MEM_LOAD_SPLIT_EN
    logic [ADDR_W-1:0] addr_r;
    logic              crossing_r;
    logic [XLEN-1:0]   lo_r;
`endif

    logic              req_legal_s;
    logic              req_crossing_s;
    logic [1:0]        req_err_s;
    logic [XLEN-1:0]   beat_lo_s;
    logic [XLEN-1:0]   beat_hi_s;
    logic              beat_done_s;
    logic [XLEN-1:0]   result_s;

    function automatic logic crosses(input logic [OFF_W-1:0] off, input logic [1:0] size_code);
        logic [4:0] size_b;
        size_b = 5'd1 << size_code;
        return (5'(off) + size_b) > 5'(NBYTES);
    endfunction

    // Classify the incoming request before it is accepted.
    always_comb begin
        req_legal_s    = func3_legal(req_func3, XLEN == 64);
        req_crossing_s = crosses(req_addr[OFF_W-1:0], req_func3[1:0]);
        if (!req_legal_s) begin
            req_err_s = ERR_ILLEGAL;
        end
`ifndef MEM_LOAD_SPLIT_EN
        else if (req_crossing_s) begin
            req_err_s = ERR_MISALIGN;
        end
`endif
        else begin
            req_err_s = ERR_NONE;
        end
    end

    // Controller next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    if (req_err_s != ERR_NONE) state_nxt_s = RESP;
                    else                       state_nxt_s = REQ0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ0: begin
                if (mem_req_ready) state_nxt_s = WAIT0;
                else               state_nxt_s = REQ0;
            end
            WAIT0: begin
                if (mem_rsp_valid) begin
`ifdef MEM_LOAD_SPLIT_EN
                    if (crossing_r) state_nxt_s = REQ1;
                    else            state_nxt_s = RESP;
`else
                    state_nxt_s = RESP;
`endif
                end else begin
                    state_nxt_s = WAIT0;
                end
            end
`ifdef MEM_LOAD_SPLIT_EN
            REQ1: begin
                if (mem_req_ready) state_nxt_s = WAIT1;
                else               state_nxt_s = REQ1;
            end
            WAIT1: begin
                if (mem_rsp_valid) state_nxt_s = RESP;
                else               state_nxt_s = WAIT1;
            end
`endif
            RESP: begin
                if (rsp_ready) state_nxt_s = IDLE;
                else           state_nxt_s = RESP;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // The final beat is combined straight from the memory bus; only the first of two is held.
    always_comb begin
`ifdef MEM_LOAD_SPLIT_EN
        if (state_r == WAIT1) begin
            beat_lo_s = lo_r;
            beat_hi_s = mem_rsp_data;
        end else begin
            beat_lo_s = mem_rsp_data;
            beat_hi_s = {XLEN{1'b0}};
        end
`else
        beat_lo_s = mem_rsp_data;
        beat_hi_s = {XLEN{1'b0}};
`endif
        beat_done_s = mem_rsp_valid && (state_nxt_s == RESP) &&
                      ((state_r == WAIT0) || (state_r == WAIT1));
    end

    load_align_extend #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_align (
        .lo     (beat_lo_s),
        .hi     (beat_hi_s),
        .off    (off_r),
        .func3  (func3_r),
        .result (result_s)
    );

    // State, capture registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= IDLE;
            req_ready_r     <= 1'b1;
            mem_req_valid_r <= 1'b0;
            rsp_valid_r     <= 1'b0;
            mem_req_addr_r  <= {ADDR_W{1'b0}};
            rsp_data_r      <= {XLEN{1'b0}};
            rsp_tag_r       <= {TAG_W{1'b0}};
            rsp_err_r       <= ERR_NONE;
            off_r           <= {OFF_W{1'b0}};
            func3_r         <= 3'b000;
`ifdef MEM_LOAD_SPLIT_EN
            addr_r          <= {ADDR_W{1'b0}};
            crossing_r      <= 1'b0;
            lo_r            <= {XLEN{1'b0}};
`endif
        end else begin
            state_r         <= state_nxt_s;
            req_ready_r     <= (state_nxt_s == IDLE);
            mem_req_valid_r <= (state_nxt_s == REQ0) || (state_nxt_s == REQ1);
            rsp_valid_r     <= (state_nxt_s == RESP);
            if ((state_r == IDLE) && req_valid) begin
                off_r          <= req_addr[OFF_W-1:0];
                func3_r        <= req_func3;
                rsp_tag_r      <= req_tag;
                rsp_err_r      <= req_err_s;
                rsp_data_r     <= {XLEN{1'b0}};
                mem_req_addr_r <= req_addr & ALIGN_MASK;
`ifdef MEM_LOAD_SPLIT_EN
                addr_r         <= req_addr;
                crossing_r     <= req_crossing_s;
`endif
            end
            if (beat_done_s) begin
                rsp_data_r <= result_s;
            end
`ifdef MEM_LOAD_SPLIT_EN
            if ((state_r == WAIT0) && mem_rsp_valid && crossing_r) begin
                lo_r           <= mem_rsp_data;
                mem_req_addr_r <= (addr_r & ALIGN_MASK) + BEAT_STRIDE;
            end
`endif
        end
    end

    assign req_ready     = req_ready_r;
    assign mem_req_valid = mem_req_valid_r;
    assign mem_req_addr  = mem_req_addr_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_data      = rsp_data_r;
    assign rsp_tag       = rsp_tag_r;
    assign rsp_err       = rsp_err_r;

endmodule
